difftest_lrsc_arbiter: RTL and testbench

//  - Collects LR/SC completion events from N_CORES cores into one ordered stream.
//  - Each core has its own event FIFO; a round-robin arbiter drains the FIFOs.
//  - Drives a single shared LR/SC difftest event sink: one event per handshake, with success bit and core id.
//  - Sits between the core commit stages and the single DPI reporting port.

---
 rtl/difftest_lrsc_pkg.sv | 15 +
 rtl/lrsc_event_fifo.sv | 44 ++++
 rtl/difftest_lrsc_arbiter.sv | 169 ++++++++++++++++
 tb/tb_difftest_lrsc_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_lrsc_pkg.sv
// Shared types and widths for the LR/SC difftest event arbiter.
// Optional statistics counters are enabled with the DIFFTEST_LRSC_STATS_EN macro.
package difftest_lrsc_pkg;

   typedef struct packed {
      logic       success;
      logic [7:0] coreid;
   } lrsc_evt_t;

   localparam int DROP_CNT_W = 16;
   localparam int STAT_CNT_W = 32;

   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/lrsc_event_fifo.sv
// Per-core event FIFO holding only the SC success bit; the core id is implied
// by which instance holds the entry. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
module lrsc_event_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [DEPTH-1:0] mem;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Storage and pointer update; push and pop may both happen in one cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         mem    <= '0;
      end else begin
         if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/difftest_lrsc_arbiter.sv
// Merges LR/SC completion events from N_CORES cores into a single registered
// stream toward the difftest sink, using per-core FIFOs and a round-robin grant.
// Define DIFFTEST_LRSC_STATS_EN to add per-core SC success/failure counters.
module difftest_lrsc_arbiter
   import difftest_lrsc_pkg::*;
#(
   parameter int N_CORES      = 2,
   parameter int DEPTH        = 4,
   parameter int CORE_ID_BASE = 0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [N_CORES-1:0]      in_valid,
   input  logic [N_CORES-1:0]      in_success,
   output logic [N_CORES-1:0]      in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_success,
   output logic [7:0]              out_coreid,
   output logic                    overflow,
   output logic [DROP_CNT_W-1:0]   drop_cnt
`ifdef DIFFTEST_LRSC_STATS_EN
   ,
   output logic [N_CORES*STAT_CNT_W-1:0] sc_ok_cnt,
   output logic [N_CORES*STAT_CNT_W-1:0] sc_fail_cnt
`endif
);

   localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   logic [N_CORES-1:0]  fifo_full;
   logic [N_CORES-1:0]  fifo_empty;
   logic [N_CORES-1:0]  fifo_dout;
   logic [N_CORES-1:0]  push_vec;
   logic [N_CORES-1:0]  pop_vec;
   logic [N_CORES-1:0]  drop_vec;

   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    rr_next;
   logic [PTR_W-1:0]    grant_idx;
   logic                grant_found;
   logic                grant_succ;
   logic                load;

   logic [DROP_CNT_W:0]   drop_sum;
   logic [DROP_CNT_W-1:0] drop_next;

   lrsc_evt_t out_evt;

   // A slot freed by a pop this cycle is not reusable until the next cycle.
   assign in_ready    = ~fifo_full;
   assign push_vec    = in_valid & ~fifo_full;
   assign drop_vec    = in_valid & fifo_full;
   assign out_success = out_evt.success;
   assign out_coreid  = out_evt.coreid;

   for (genvar i = 0; i < N_CORES; i++) begin : g_fifo
      lrsc_event_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clock   (clock),
         .reset_n (reset_n),
         .push    (push_vec[i]),
         .din     (in_success[i]),
         .pop     (pop_vec[i]),
         .dout    (fifo_dout[i]),
         .full    (fifo_full[i]),
         .empty   (fifo_empty[i])
      );
   end

   // Round-robin search: first non-empty FIFO at or above rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_succ  = 1'b0;
      for (int k = 0; k < N_CORES; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_CORES) idx = idx - N_CORES;
         if (!grant_found && !fifo_empty[idx]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(idx);
            grant_succ  = fifo_dout[idx];
         end
      end
   end

   // Output register may take a new event when empty or being drained.
   always_comb begin
      load    = (!out_valid || out_ready) && grant_found;
      rr_next = (int'(grant_idx) == N_CORES - 1) ? '0 : PTR_W'(int'(grant_idx) + 1);
      pop_vec = '0;
      for (int i = 0; i < N_CORES; i++) begin
         pop_vec[i] = load && (int'(grant_idx) == i);
      end
   end

   // Drop total for this cycle, clamped at the counter's maximum.
   always_comb begin
      drop_sum = {1'b0, drop_cnt};
      for (int i = 0; i < N_CORES; i++) begin
         drop_sum = drop_sum + (DROP_CNT_W+1)'(drop_vec[i]);
      end
      drop_next = drop_sum[DROP_CNT_W] ? DROP_CNT_MAX : drop_sum[DROP_CNT_W-1:0];
   end

   // Presented event and round-robin pointer; event fields hold while stalled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_evt   <= '0;
         rr_ptr    <= '0;
      end else if (load) begin
         out_valid      <= 1'b1;
         out_evt.success <= grant_succ;
         out_evt.coreid  <= 8'(CORE_ID_BASE + int'(grant_idx));
         rr_ptr         <= rr_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         overflow <= overflow | (|drop_vec);
         drop_cnt <= drop_next;
      end
   end

`ifdef DIFFTEST_LRSC_STATS_EN
   logic [PTR_W-1:0] out_idx;

   // Remember which requester the presented event came from.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_idx <= '0;
      end else if (load) begin
         out_idx <= grant_idx;
      end
   end

   // Per-core wrapping success/failure counters, bumped on each handshake.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sc_ok_cnt   <= '0;
         sc_fail_cnt <= '0;
      end else if (out_valid && out_ready) begin
         for (int i = 0; i < N_CORES; i++) begin
            if (int'(out_idx) == i) begin
               if (out_evt.success) begin
                  sc_ok_cnt[i*STAT_CNT_W +: STAT_CNT_W] <=
                     sc_ok_cnt[i*STAT_CNT_W +: STAT_CNT_W] + STAT_CNT_W'(1);
               end else begin
                  sc_fail_cnt[i*STAT_CNT_W +: STAT_CNT_W] <=
                     sc_fail_cnt[i*STAT_CNT_W +: STAT_CNT_W] + STAT_CNT_W'(1);
               end
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_difftest_lrsc_arbiter.sv
// Self-checking bench for difftest_lrsc_arbiter (4 cores, depth 4).
// Build with DIFFTEST_LRSC_STATS_EN defined to also exercise the stats counters.
module tb_difftest_lrsc_arbiter;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int BASE  = 0;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b1;
   logic [N-1:0]  in_valid   = '0;
   logic [N-1:0]  in_success = '0;
   logic [N-1:0]  in_ready;
   logic          out_valid;
   logic          out_ready  = 1'b0;
   logic          out_success;
   logic [7:0]    out_coreid;
   logic          overflow;
   logic [15:0]   drop_cnt;
`ifdef DIFFTEST_LRSC_STATS_EN
   logic [N*32-1:0] sc_ok_cnt;
   logic [N*32-1:0] sc_fail_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: one queue of success bits per core plus the presented event.
   bit          mq [N][$];
   int          m_rr;
   bit          m_out_valid;
   bit          m_out_succ;
   int          m_out_core;
   int          m_drop;
   bit          m_overflow;
   int unsigned m_ok   [N];
   int unsigned m_fail [N];

   difftest_lrsc_arbiter #(
      .N_CORES      (N),
      .DEPTH        (DEPTH),
      .CORE_ID_BASE (BASE)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_success  (in_success),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_success (out_success),
      .out_coreid  (out_coreid),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt)
`ifdef DIFFTEST_LRSC_STATS_EN
      ,
      .sc_ok_cnt   (sc_ok_cnt),
      .sc_fail_cnt (sc_fail_cnt)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mq[i].delete();
         m_ok[i]   = 0;
         m_fail[i] = 0;
      end
      m_rr        = 0;
      m_out_valid = 0;
      m_out_succ  = 0;
      m_out_core  = 0;
      m_drop      = 0;
      m_overflow  = 0;
   endtask

   // One clock of the model: handshake, then pop into the output, then pushes
   // judged against the occupancy seen at the start of the cycle.
   task automatic modelStep(input logic [N-1:0] v, input logic [N-1:0] s, input logic rdy);
      bit full_pre [N];
      bit granted;
      int g;
      int c;
      granted = 0;
      g = 0;
      for (int i = 0; i < N; i++) full_pre[i] = (mq[i].size() >= DEPTH);
      if (m_out_valid && rdy) begin
         if (m_out_succ) m_ok[m_out_core]++;
         else            m_fail[m_out_core]++;
      end
      if (!m_out_valid || rdy) begin
         for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (!granted && mq[c].size() > 0) begin
               granted = 1;
               g = c;
            end
         end
      end
      if (granted) begin
         m_out_succ  = mq[g].pop_front();
         m_out_valid = 1;
         m_out_core  = g;
         m_rr        = (g + 1) % N;
      end else if (rdy) begin
         m_out_valid = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            if (!full_pre[i]) mq[i].push_back(s[i]);
            else begin
               m_overflow = 1;
               if (m_drop < 65535) m_drop++;
            end
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model, and move to just past the edge.
   task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] s, input logic rdy);
      in_valid   = v;
      in_success = s;
      out_ready  = rdy;
      modelStep(v, s, rdy);
      @(posedge clock);
      #1;
   endtask

   // Compare every observable output against the model.
   task automatic checkOutput(input string tag);
      logic [N-1:0] exp_rdy;
      for (int i = 0; i < N; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
      check($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(m_out_valid));
      if (m_out_valid) begin
         check($sformatf("%s.out_success", tag), 32'(out_success), 32'(m_out_succ));
         check($sformatf("%s.out_coreid", tag), 32'(out_coreid), 32'(8'(BASE + m_out_core)));
      end
      check($sformatf("%s.in_ready", tag), 32'(in_ready), 32'(exp_rdy));
      check($sformatf("%s.overflow", tag), 32'(overflow), 32'(m_overflow));
      check($sformatf("%s.drop_cnt", tag), 32'(drop_cnt), 32'(m_drop));
`ifdef DIFFTEST_LRSC_STATS_EN
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s.sc_ok[%0d]", tag, i), sc_ok_cnt[i*32 +: 32], m_ok[i]);
         check($sformatf("%s.sc_fail[%0d]", tag, i), sc_fail_cnt[i*32 +: 32], m_fail[i]);
      end
`endif
   endtask

   // Assert reset between edges, confirm the immediate effect, then release.
   task automatic doReset();
      in_valid   = '0;
      in_success = '0;
      out_ready  = 1'b0;
      reset_n    = 1'b0;
      #1;
      modelReset();
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'hF);
      check("rst.out_coreid", 32'(out_coreid), 32'd0);
      check("rst.out_success", 32'(out_success), 32'd0);
      check("rst.overflow", 32'(overflow), 32'd0);
      check("rst.drop_cnt", 32'(drop_cnt), 32'd0);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] bp_succ;
      logic [N-1:0] rv;
      logic [N-1:0] rs;

      #1;
      doReset();

      // Single event from core 1: presented one cycle after acceptance, for one cycle.
      $display("[TB] single event");
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      checkOutput("single0");
      check("single0.valid", 32'(out_valid), 32'd0);
      applyStimulus('0, '0, 1'b1);
      checkOutput("single1");
      check("single1.valid", 32'(out_valid), 32'd1);
      check("single1.coreid", 32'(out_coreid), 32'd1);
      check("single1.success", 32'(out_success), 32'd1);
      applyStimulus('0, '0, 1'b1);
      checkOutput("single2");
      check("single2.valid", 32'(out_valid), 32'd0);

      // Fairness: every core pushes every cycle; grants rotate 0,1,2,3,...
      @(posedge clock);
      #1;
      doReset();
      $display("[TB] fairness");
      for (int k = 0; k < 12; k++) begin
         applyStimulus('1, N'($urandom), 1'b1);
         checkOutput("fair");
         if (k >= 1) check("fair.seq", 32'(out_coreid), 32'((k - 1) % N));
      end

      // Backpressure: sink stalls while core 0 pushes six events.
      @(posedge clock);
      #1;
      doReset();
      $display("[TB] backpressure");
      bp_succ = 4'b1101;
      for (int k = 0; k < 10; k++) begin
         if (k < 6) applyStimulus(4'b0001, {3'b000, (k == 0) ? 1'b1 : bp_succ[k % 4]}, 1'b0);
         else       applyStimulus('0, '0, 1'b0);
         checkOutput("bp");
         if (k >= 1) check("bp.hold_success", 32'(out_success), 32'd1);
         if (k >= 1) check("bp.hold_coreid", 32'(out_coreid), 32'd0);
      end
      check("bp.in_ready0", 32'(in_ready[0]), 32'd0);
      check("bp.overflow", 32'(overflow), 32'd1);
      check("bp.drop_cnt", 32'(drop_cnt), 32'd1);
      for (int k = 0; k < 7; k++) begin
         applyStimulus('0, '0, 1'b1);
         checkOutput("bp_drain");
      end

      // Randomised traffic with random sink backpressure.
      @(posedge clock);
      #1;
      doReset();
      $display("[TB] random traffic");
      for (int k = 0; k < 300; k++) begin
         rv = N'($urandom);
         rs = N'($urandom);
         applyStimulus(rv, rs, ($urandom_range(0, 3) != 0));
         checkOutput("rand");
      end

      // Async reset with events queued and one presented.
      $display("[TB] async reset");
      for (int k = 0; k < 4; k++) begin
         applyStimulus('1, N'($urandom), 1'b0);
      end
      checkOutput("pre_rst");
      doReset();
      for (int k = 0; k < 5; k++) begin
         applyStimulus('0, '0, 1'b1);
         checkOutput("post_rst");
         check("post_rst.valid", 32'(out_valid), 32'd0);
      end

      // Saturation: four drops per cycle once all FIFOs fill.
      $display("[TB] drop counter saturation");
      for (int k = 0; k < 17600; k++) begin
         applyStimulus('1, N'($urandom), 1'b0);
         if (k == 16000) checkOutput("sat_mid");
      end
      checkOutput("sat");
      check("sat.drop_cnt", 32'(drop_cnt), 32'hFFFF);
      check("sat.overflow", 32'(overflow), 32'd1);
      for (int k = 0; k < 10; k++) begin
         applyStimulus('1, N'($urandom), 1'b0);
      end
      check("sat_hold.drop_cnt", 32'(drop_cnt), 32'hFFFF);
      check("sat_hold.overflow", 32'(overflow), 32'd1);

`ifdef DIFFTEST_LRSC_STATS_EN
      // Statistics: core 1 reports three successes then two failures.
      @(posedge clock);
      #1;
      doReset();
      $display("[TB] stats counters");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b0010, (k < 3) ? 4'b0010 : 4'b0000, 1'b1);
         checkOutput("stats");
      end
      for (int k = 0; k < 3; k++) begin
         applyStimulus('0, '0, 1'b1);
         checkOutput("stats_drain");
      end
      for (int i = 0; i < N; i++) begin
         check($sformatf("stats.ok[%0d]", i), sc_ok_cnt[i*32 +: 32], (i == 1) ? 32'd3 : 32'd0);
         check($sformatf("stats.fail[%0d]", i), sc_fail_cnt[i*32 +: 32], (i == 1) ? 32'd2 : 32'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
